// File: rtl/move_sequencer.sv
// move_sequencer: turn controller for a tic-tac-toe board.
// Accepts player (play/player_pos) and computer (comp_valid/comp_pos) move
// requests, checks legality against its own occupancy record, drives the
// shared decoder position bus with a one-cycle enable per accepted move,
// and detects win/draw, holding the result until restart.
// Ports:
//   clock, reset (async active-low), restart (sync clear)
//   play, player_pos     : player request, sampled in IDLE only
//   comp_valid, comp_pos : computer request, sampled in PC_WAIT only
//   dec_pos, pl_dec_en, pc_dec_en : decoder bus and per-player enables
//   illegal_move         : one-cycle pulse on a rejected request
//   turn                 : 0 player to move, 1 computer to move
//   board_x, board_o     : player / computer occupancy
//   winner               : 00 none, 01 player, 10 computer, 11 draw
//   game_over            : high while the game is finished
`timescale 1ns/1ps
module move_sequencer #(
  parameter int CELLS = 9,
  parameter int POS_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             play,
  input  logic [POS_W-1:0] player_pos,
  input  logic             comp_valid,
  input  logic [POS_W-1:0] comp_pos,
  output logic [POS_W-1:0] dec_pos,
  output logic             pl_dec_en,
  output logic             pc_dec_en,
  output logic             illegal_move,
  output logic             turn,
  output logic [CELLS-1:0] board_x,
  output logic [CELLS-1:0] board_o,
  output logic [1:0]       winner,
  output logic             game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PL_COMMIT = 3'd1,
    PC_WAIT   = 3'd2,
    PC_COMMIT = 3'd3,
    CHECK     = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_PL   = 2'b01;
  localparam logic [1:0] WIN_PC   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // One-hot mask of a cell; positions outside the board give an empty mask.
  function automatic logic [CELLS-1:0] cell_mask(input logic [POS_W-1:0] p);
    logic [CELLS-1:0] m;
    m = {CELLS{1'b0}};
    for (int i = 0; i < CELLS; i++) begin
      m[i] = (p == POS_W'(i));
    end
    return m;
  endfunction

  function automatic logic is_legal(input logic [POS_W-1:0] p,
                                    input logic [CELLS-1:0] bx,
                                    input logic [CELLS-1:0] bo);
    return (p < POS_W'(CELLS)) && ((cell_mask(p) & (bx | bo)) == {CELLS{1'b0}});
  endfunction

  // Any of the 8 lines (rows, columns, diagonals) fully owned.
  function automatic logic has_line(input logic [CELLS-1:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  state_t           state_r, state_s;
  logic [POS_W-1:0] dec_pos_r, dec_pos_s;
  logic             pl_en_r, pl_en_s, pc_en_r, pc_en_s;
  logic             illegal_r, illegal_s, turn_r, turn_s;
  logic [CELLS-1:0] board_x_r, board_x_s, board_o_r, board_o_s;
  logic [1:0]       winner_r, winner_s;
  logic             game_over_r, game_over_s;
  logic [CELLS-1:0] mover_board_s;

  // Next-state and next-output computation; restart overrides everything.
  always_comb begin
    state_s       = state_r;
    dec_pos_s     = dec_pos_r;
    pl_en_s       = 1'b0;
    pc_en_s       = 1'b0;
    illegal_s     = 1'b0;
    turn_s        = turn_r;
    board_x_s     = board_x_r;
    board_o_s     = board_o_r;
    winner_s      = winner_r;
    game_over_s   = game_over_r;
    mover_board_s = turn_r ? board_o_r : board_x_r;

    case (state_r)
      IDLE: begin
        if (play) begin
          if (is_legal(player_pos, board_x_r, board_o_r)) begin
            // dec_pos doubles as the latched move position.
            dec_pos_s = player_pos;
            pl_en_s   = 1'b1;
            state_s   = PL_COMMIT;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PL_COMMIT: begin
        board_x_s = board_x_r | cell_mask(dec_pos_r);
        state_s   = CHECK;
      end
      PC_WAIT: begin
        if (comp_valid) begin
          if (is_legal(comp_pos, board_x_r, board_o_r)) begin
            dec_pos_s = comp_pos;
            pc_en_s   = 1'b1;
            state_s   = PC_COMMIT;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_s = PC_WAIT;
        end
      end
      PC_COMMIT: begin
        board_o_s = board_o_r | cell_mask(dec_pos_r);
        state_s   = CHECK;
      end
      CHECK: begin
        // turn still identifies the mover here; it only flips on a continue.
        if (has_line(mover_board_s)) begin
          winner_s    = turn_r ? WIN_PC : WIN_PL;
          game_over_s = 1'b1;
          state_s     = DONE;
        end else if ((board_x_r | board_o_r) == {CELLS{1'b1}}) begin
          winner_s    = WIN_DRAW;
          game_over_s = 1'b1;
          state_s     = DONE;
        end else begin
          turn_s  = ~turn_r;
          state_s = turn_r ? IDLE : PC_WAIT;
        end
      end
      DONE: begin
        state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (restart) begin
      state_s     = IDLE;
      dec_pos_s   = {POS_W{1'b0}};
      pl_en_s     = 1'b0;
      pc_en_s     = 1'b0;
      illegal_s   = 1'b0;
      turn_s      = 1'b0;
      board_x_s   = {CELLS{1'b0}};
      board_o_s   = {CELLS{1'b0}};
      winner_s    = WIN_NONE;
      game_over_s = 1'b0;
    end else begin
      game_over_s = game_over_s;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      dec_pos_r   <= {POS_W{1'b0}};
      pl_en_r     <= 1'b0;
      pc_en_r     <= 1'b0;
      illegal_r   <= 1'b0;
      turn_r      <= 1'b0;
      board_x_r   <= {CELLS{1'b0}};
      board_o_r   <= {CELLS{1'b0}};
      winner_r    <= WIN_NONE;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      dec_pos_r   <= dec_pos_s;
      pl_en_r     <= pl_en_s;
      pc_en_r     <= pc_en_s;
      illegal_r   <= illegal_s;
      turn_r      <= turn_s;
      board_x_r   <= board_x_s;
      board_o_r   <= board_o_s;
      winner_r    <= winner_s;
      game_over_r <= game_over_s;
    end
  end

  assign dec_pos      = dec_pos_r;
  assign pl_dec_en    = pl_en_r;
  assign pc_dec_en    = pc_en_r;
  assign illegal_move = illegal_r;
  assign turn         = turn_r;
  assign board_x      = board_x_r;
  assign board_o      = board_o_r;
  assign winner       = winner_r;
  assign game_over    = game_over_r;

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: directed moves with a scoreboard of expected
// decoder enables, illegal pulses and game-over results.
`timescale 1ns/1ps
module tb_move_sequencer;
  localparam int K_PL = 0, K_PC = 1, K_ILL = 2, K_DONE = 3;

  logic       clock = 1'b0, reset = 1'b0, restart = 1'b0;
  logic       play = 1'b0, comp_valid = 1'b0;
  logic [3:0] player_pos = 4'd0, comp_pos = 4'd0;
  logic [3:0] dec_pos;
  logic       pl_dec_en, pc_dec_en, illegal_move, turn, game_over;
  logic [8:0] board_x, board_o;
  logic [1:0] winner;

  move_sequencer #(.CELLS(9), .POS_W(4)) dut (
    .clock(clock), .reset(reset), .restart(restart), .play(play),
    .player_pos(player_pos), .comp_valid(comp_valid), .comp_pos(comp_pos),
    .dec_pos(dec_pos), .pl_dec_en(pl_dec_en), .pc_dec_en(pc_dec_en),
    .illegal_move(illegal_move), .turn(turn), .board_x(board_x),
    .board_o(board_o), .winner(winner), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;
    logic [3:0] pos;
    logic [1:0] win;
    logic [8:0] bx;
    logic [8:0] bo;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0, fails = 0;
  int   pc_count = 0;
  int   act_kind;
  logic go_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every enable, illegal pulse or game-over rise pops one expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (pc_dec_en) pc_count <= pc_count + 1;
      if (pl_dec_en || pc_dec_en || illegal_move || (game_over && !go_prev)) begin
        chk("enable_exclusive", {31'd0, pl_dec_en && pc_dec_en}, 32'd0);
        act_kind = pl_dec_en ? K_PL : pc_dec_en ? K_PC : illegal_move ? K_ILL : K_DONE;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got kind %0d expected none", act_kind);
        end else begin
          cur = q.pop_front();
          chk("event_kind", act_kind, cur.kind);
          if (act_kind == K_PL || act_kind == K_PC) chk("dec_pos", {28'd0, dec_pos}, {28'd0, cur.pos});
          if (act_kind == K_DONE) begin
            chk("winner", {30'd0, winner}, {30'd0, cur.win});
            chk("final_board_x", {23'd0, board_x}, {23'd0, cur.bx});
            chk("final_board_o", {23'd0, board_o}, {23'd0, cur.bo});
          end
        end
      end
      go_prev <= game_over;
    end else begin
      go_prev <= 1'b0;
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int kind, input logic [3:0] pos, input logic [1:0] win,
                      input logic [8:0] bx, input logic [8:0] bo);
    exp_t e;
    e.kind = kind; e.pos = pos; e.win = win; e.bx = bx; e.bo = bo;
    q.push_back(e);
  endtask

  // Legal move; runs through commit and check (3 cycles).
  task automatic mv(input logic is_pc, input logic [3:0] pos, input logic done,
                    input logic [1:0] win, input logic [8:0] bx, input logic [8:0] bo);
    push(is_pc ? K_PC : K_PL, pos, 2'b00, 9'd0, 9'd0);
    if (done) push(K_DONE, 4'd0, win, bx, bo);
    if (is_pc) begin comp_valid = 1'b1; comp_pos = pos; end
    else begin play = 1'b1; player_pos = pos; end
    step;
    play = 1'b0; comp_valid = 1'b0;
    step;
    step;
  endtask

  task automatic bad(input logic is_pc, input logic [3:0] pos);
    push(K_ILL, 4'd0, 2'b00, 9'd0, 9'd0);
    if (is_pc) begin comp_valid = 1'b1; comp_pos = pos; end
    else begin play = 1'b1; player_pos = pos; end
    step;
    play = 1'b0; comp_valid = 1'b0;
    step;
  endtask

  task automatic do_restart;
    restart = 1'b1;
    step;
    restart = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_dec_pos"}, {28'd0, dec_pos}, 32'd0);
    chk({tag, "_enables"}, {30'd0, pl_dec_en, pc_dec_en}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal_move}, 32'd0);
    chk({tag, "_turn"}, {31'd0, turn}, 32'd0);
    chk({tag, "_board_x"}, {23'd0, board_x}, 32'd0);
    chk({tag, "_board_o"}, {23'd0, board_o}, 32'd0);
    chk({tag, "_winner"}, {30'd0, winner}, 32'd0);
    chk({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
  endtask

  int base;

  initial begin
    step;
    step;
    chk_reset_values("reset");
    reset = 1'b1;
    step;

    // Out-of-range position in IDLE.
    bad(1'b0, 4'd9);
    chk("after_pos9_board", {23'd0, board_x | board_o}, 32'd0);

    // Legal player move on 4 with latency checks.
    push(K_PL, 4'd4, 2'b00, 9'd0, 9'd0);
    play = 1'b1; player_pos = 4'd4;
    step;
    play = 1'b0;
    chk("lat_pl_en", {31'd0, pl_dec_en}, 32'd1);
    chk("lat_board_pending", {23'd0, board_x}, 32'd0);
    step;
    chk("lat_board_x", {23'd0, board_x}, 32'h010);
    chk("lat_turn_check", {31'd0, turn}, 32'd0);
    step;
    chk("lat_turn_pc", {31'd0, turn}, 32'd1);

    // play outside IDLE is ignored.
    play = 1'b1; player_pos = 4'd5;
    step;
    play = 1'b0;
    step;
    chk("ignored_play_board", {23'd0, board_x}, 32'h010);

    // Computer onto occupied cell, then a legal computer move.
    bad(1'b1, 4'd4);
    chk("pc_illegal_board_o", {23'd0, board_o}, 32'd0);
    chk("pc_illegal_turn", {31'd0, turn}, 32'd1);
    mv(1'b1, 4'd0, 1'b0, 2'b00, 9'd0, 9'd0);
    chk("pc_move_board_o", {23'd0, board_o}, 32'h001);
    chk("pc_move_turn", {31'd0, turn}, 32'd0);
    bad(1'b0, 4'd4);
    chk("pl_occupied_board_x", {23'd0, board_x}, 32'h010);
    do_restart;
    chk_reset_values("restart");

    // Player wins on the top row.
    mv(1'b0, 4'd0, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd3, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd1, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd4, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd2, 1'b1, 2'b01, 9'h007, 9'h018);
    chk("pl_win_game_over", {31'd0, game_over}, 32'd1);
    play = 1'b1; player_pos = 4'd5;
    step;
    play = 1'b0; comp_valid = 1'b1; comp_pos = 4'd5;
    step;
    comp_valid = 1'b0;
    step;
    chk("done_hold_board_x", {23'd0, board_x}, 32'h007);
    chk("done_hold_winner", {30'd0, winner}, 32'd1);
    do_restart;

    // Draw.
    mv(1'b0, 4'd0, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd1, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd2, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd4, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd3, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd5, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd7, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd6, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd8, 1'b1, 2'b11, 9'h18D, 9'h072);
    chk("draw_full", {23'd0, board_x | board_o}, 32'h1FF);
    chk("draw_game_over", {31'd0, game_over}, 32'd1);
    do_restart;

    // Computer wins on the anti-diagonal.
    base = pc_count;
    mv(1'b0, 4'd0, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd2, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd1, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd4, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b0, 4'd3, 1'b0, 2'b00, 9'd0, 9'd0);
    mv(1'b1, 4'd6, 1'b1, 2'b10, 9'h00B, 9'h054);
    chk("pc_en_count", pc_count - base, 32'd3);
    do_restart;

    // Restart in the same cycle as pl_dec_en discards the move.
    push(K_PL, 4'd4, 2'b00, 9'd0, 9'd0);
    play = 1'b1; player_pos = 4'd4;
    step;
    play = 1'b0; restart = 1'b1;
    step;
    restart = 1'b0;
    chk_reset_values("restart_inflight");
    step;
    step;
    chk("restart_no_commit", {23'd0, board_x}, 32'd0);
    chk("restart_turn", {31'd0, turn}, 32'd0);

    // Asynchronous reset in PC_WAIT between clock edges.
    mv(1'b0, 4'd4, 1'b0, 2'b00, 9'd0, 9'd0);
    chk("pre_reset_turn", {31'd0, turn}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_values("async_reset");
    step;
    reset = 1'b1;
    step;

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Turn controller for the tic-tac-toe board. It accepts move requests from the human player and the computer player and checks each move for legality against its own occupancy record. It sequences the position decoders by driving a shared position bus plus one decoder enable per player. It also detects win and draw conditions and holds the game in a finished state until a restart.

Parameters:
CELLS, 9, number of playable cells; positions CELLS..15 are illegal
POS_W, 4, width of position buses (matches 4-bit decoder input)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
restart  input  1  synchronous clear of board and FSM to IDLE
play  input  1  player move request, sampled only in IDLE
player_pos  input  POS_W  player target cell
comp_valid  input  1  computer move request, sampled only in PC_WAIT
comp_pos  input  POS_W  computer target cell
dec_pos  output  POS_W  position bus to both decoders
pl_dec_en  output  1  enable for player decoder
pc_dec_en  output  1  enable for computer decoder
illegal_move  output  1  one-cycle pulse on rejected request
turn  output  1  0 = player to move, 1 = computer to move
board_x  output  CELLS  player occupancy
board_o  output  CELLS  computer occupancy
winner  output  2  00 none, 01 player, 10 computer, 11 draw
game_over  output  1  high in DONE

Behaviour:
- Reset (reset=0, async): state IDLE; board_x = 0, board_o = 0, dec_pos = 0, pl_dec_en = 0, pc_dec_en = 0, illegal_move = 0, turn = 0, winner = 00, game_over = 0.
- FSM states: IDLE, PL_COMMIT, PC_WAIT, PC_COMMIT, CHECK, DONE.
- A request is legal when pos < CELLS and board_x[pos] = 0 and board_o[pos] = 0.
- IDLE:
  - play=1 and legal -> latch pos, go to PL_COMMIT.
  - play=1 and illegal -> illegal_move=1 for the next cycle only; stay in IDLE.
- PL_COMMIT: one cycle. pl_dec_en=1 and dec_pos=latched pos. board_x[pos] is set at the end of this cycle. Go to CHECK with mover=player.
- PC_WAIT (turn=1):
  - comp_valid=1 and legal -> latch pos, go to PC_COMMIT.
  - comp_valid=1 and illegal -> one-cycle illegal_move pulse; stay in PC_WAIT.
  - No timeout.
- PC_COMMIT: mirror of PL_COMMIT using pc_dec_en and board_o.
- CHECK: one cycle; uses the already-updated board. Only the mover's 8 lines are evaluated (3 rows, 3 columns, 2 diagonals).
  - Mover has a line -> winner = 01 or 10, go to DONE.
  - Else board_x|board_o all ones -> winner = 11, go to DONE.
  - Else toggle turn and go to PC_WAIT (player moved) or IDLE (computer moved).
- DONE: game_over=1. play and comp_valid are ignored, with no illegal pulse. Outputs hold.
- Enables are high for exactly one cycle per accepted move and never both high together. dec_pos holds its last value when the enables are low.
- Latency: play at cycle N -> pl_dec_en at N+1 -> board_x visible and CHECK at N+2 -> PC_WAIT (turn=1) at N+3.
- play in any state other than IDLE, or comp_valid outside PC_WAIT: ignored, no illegal pulse, no state change.
- restart=1 in any state takes priority over all other inputs. Next cycle matches the reset values. A move in flight, including an enable pulse already issued, is discarded from the board.
- reset asserted mid-operation: immediate return to reset values, regardless of the clock.
- Win lines (index = row*3+col): {0,1,2} {3,4,5} {6,7,8} {0,3,6} {1,4,7} {2,5,8} {0,4,8} {2,4,6}. Bits 9..15 are not part of the board.

Test Plan:
- Legal player move: play=1, player_pos=4 in IDLE -> pl_dec_en=1, dec_pos=4 the next cycle; board_x=9'h010 one cycle later; turn=1 at N+3; illegal_move stays 0.
- Illegal requests: player_pos=9, then player_pos=4 onto an occupied cell, then comp_pos=4 in PC_WAIT -> one-cycle illegal_move each time; no enable; state and board unchanged.
- Player win: player takes 0, 1, 2 while the computer takes 3, 4 -> winner=01 and game_over=1 two cycles after the third pl_dec_en; a later play is ignored.
- Draw: X=0,2,3,7,8 and O=1,4,5,6 -> after the last commit, board_x|board_o=9'h1FF, winner=11, game_over=1.
- Computer win on a diagonal: O on 2, 4, 6 -> winner=10 and pc_dec_en seen exactly 3 times.
- Restart and reset: restart asserted in the same cycle as pl_dec_en -> board cleared next cycle, IDLE, turn=0. reset pulsed low mid-PC_WAIT between clock edges -> all outputs return to reset values immediately.
